pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the RV32IM 5-stage pipeline.
- Drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
- Resolves load-use hazards, taken-branch/jump redirects, multi-cycle MUL/DIV occupancy of EX, and instruction-memory wait.
- Sits beside the datapath; all outputs are combinational from the registered FSM state and the current-cycle inputs.

Parameters:
MULDIV_CYCLES, 4, total cycles a MUL/DIV instruction occupies EX; legal range 2..32.
CNT_W, 5, width of the MUL/DIV down-counter; must satisfy 2^CNT_W > MULDIV_CYCLES.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high
id_rs1  input  5  rs1 field of instruction in ID
id_rs2  input  5  rs2 field of instruction in ID
id_use_rs1  input  1  ID instruction reads rs1
id_use_rs2  input  1  ID instruction reads rs2
ex_rd  input  5  destination register of instruction in EX
ex_mem_read  input  1  EX instruction is a load
ex_muldiv_valid  input  1  EX holds a MUL/DIV/REM instruction
ex_branch_taken  input  1  EX resolved a taken branch or a jump (JAL/JALR)
imem_ready  input  1  instruction memory returns a valid word this cycle
pc_write_en  output  1  PC register load enable
pc_redirect  output  1  PC mux selects the EX branch target
if_id_write_en  output  1  IF/ID load enable (0 = hold)
if_id_flush  output  1  IF/ID loads NOP (0x00000013) and PC+4 = 0
id_ex_write_en  output  1  ID/EX load enable
id_ex_flush  output  1  ID/EX loads a bubble (all control bits 0)
ex_mem_flush  output  1  EX/MEM loads a bubble

Behaviour:
Reset (synchronous, active-high):
- state <= RUN, cnt <= 0.
- While reset=1, outputs are: pc_write_en=0, pc_redirect=0, if_id_write_en=1, if_id_flush=1, id_ex_write_en=1, id_ex_flush=1, ex_mem_flush=1.
- Reset mid-MULDIV aborts the sequence; the first cycle after reset deasserts is in RUN.

Default outputs in RUN with no event:
- pc_write_en=1, if_id_write_en=1, id_ex_write_en=1, all flushes=0, pc_redirect=0.

Load-use condition LU:
- LU = ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).

RUN state, evaluated in priority order (highest first):
1. ex_muldiv_valid:
   - pc_write_en=0, if_id_write_en=0, id_ex_write_en=0, ex_mem_flush=1.
   - cnt <= MULDIV_CYCLES-2; next state MULDIV.
   - ex_branch_taken in the same cycle is illegal and is ignored.
2. ex_branch_taken:
   - pc_write_en=1, pc_redirect=1, if_id_flush=1, id_ex_flush=1.
   - LU is ignored, because the ID instruction is on the wrong path.
   - Penalty is 2 bubbles.
3. LU:
   - pc_write_en=0, if_id_write_en=0, id_ex_flush=1.
   - Exactly one bubble; LU clears the next cycle as the load moves to MEM.
4. !imem_ready:
   - pc_write_en=0, if_id_flush=1; downstream advances normally.

MULDIV state:
- If cnt != 0: same stall outputs as RUN rule 1; cnt <= cnt-1.
- If cnt == 0: default RUN outputs (the MUL/DIV result advances to MEM); next state RUN.
- ex_muldiv_valid, ex_branch_taken and LU are not evaluated while in MULDIV.
- The stall lasts MULDIV_CYCLES-1 cycles; EX occupancy is MULDIV_CYCLES cycles.

Back-to-back MUL/DIV:
- The second instruction enters EX on the RUN-exit edge.
- It is re-detected the next cycle with no gap cycle and gets its own full stall.

Simultaneous hold and flush:
- Hold (write_en=0) overrides flush on the same register. The ID instruction is preserved.

Optional Feature:
Macro HAZARD_STATS_EN.
- Defined: adds output ports stall_cycles [31:0] and flush_events [31:0].
  - stall_cycles increments every cycle pc_write_en=0 for hazard reasons (rules 1, 3 and the MULDIV stall).
  - flush_events increments once per ex_branch_taken acceptance.
  - Both counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: the ports and counters are absent; core behaviour is identical.

Test Plan:
- Load x5 in EX (ex_mem_read=1, ex_rd=5), ID reads rs1=5 -> exactly one cycle with pc_write_en=0, if_id_write_en=0, id_ex_flush=1; normal the next cycle.
- Same as above but ex_rd=0, or id_use_rs1=0 -> no stall.
- ex_muldiv_valid=1 with MULDIV_CYCLES=4 -> stall for 3 consecutive cycles with ex_mem_flush=1, then 1 cycle with default outputs; FSM back in RUN.
- ex_branch_taken=1 together with LU -> pc_redirect=1, if_id_flush=1, id_ex_flush=1, pc_write_en=1, no hold.
- imem_ready=0 for 2 cycles during a MULDIV stall -> hold wins (if_id_flush=0); after the stall ends with imem_ready=0 -> if_id_flush=1, pc_write_en=0.
- reset asserted in the 2nd MULDIV stall cycle -> reset output values while reset=1; the first post-reset cycle with no events shows default RUN outputs.
- HAZARD_STATS_EN defined -> stall_cycles counts the 3 stall cycles of the MULDIV case, and flush_events increments by 1 per taken branch.

Source files
------------

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the RV32IM datapath and pipeline_hazard_ctrl.
// The datapath side is the master; the controller side is the slave.
interface pipeline_hazard_ctrl_if;
    // hazard-detection inputs, sourced by the datapath
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_muldiv_valid;
    logic       ex_branch_taken;
    logic       imem_ready;

    // pipeline-register controls, sourced by the controller
    logic       pc_write_en;
    logic       pc_redirect;
    logic       if_id_write_en;
    logic       if_id_flush;
    logic       id_ex_write_en;
    logic       id_ex_flush;
    logic       ex_mem_flush;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_muldiv_valid, ex_branch_taken, imem_ready,
        input  pc_write_en, pc_redirect, if_id_write_en, if_id_flush,
               id_ex_write_en, id_ex_flush, ex_mem_flush
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_mem_read,
               ex_muldiv_valid, ex_branch_taken, imem_ready,
        output pc_write_en, pc_redirect, if_id_write_en, if_id_flush,
               id_ex_write_en, id_ex_flush, ex_mem_flush
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32IM pipeline (load-use, redirect, MUL/DIV, imem wait).
// Define HAZARD_STATS_EN to add saturating stall_cycles / flush_events counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned MULDIV_CYCLES = 4,
    parameter int unsigned CNT_W         = 5
) (
    input  logic                    clk,
    input  logic                    reset,
    pipeline_hazard_ctrl_if.slave   hz
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]             stall_cycles,
    output logic [31:0]             flush_events
`endif
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 32'd2);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_MULDIV = 1'b1
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] next_cnt;

    logic load_use;
    logic rs1_hit;
    logic rs2_hit;
    logic hazard_stall;
    logic branch_accept;

    logic pc_write_en;
    logic pc_redirect;
    logic if_id_write_en;
    logic if_id_flush;
    logic id_ex_write_en;
    logic id_ex_flush;
    logic ex_mem_flush;

    // Load-use: an x0 destination never creates a dependency
    always_comb begin
        rs1_hit  = hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd);
        rs2_hit  = hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd);
        load_use = hz.ex_mem_read && (hz.ex_rd != 5'd0) && (rs1_hit || rs2_hit);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    // Next-state and pipeline controls; holds never assert a flush on the same register
    always_comb begin
        next_state     = state;
        next_cnt       = cnt;
        hazard_stall   = 1'b0;
        branch_accept  = 1'b0;
        pc_write_en    = 1'b1;
        pc_redirect    = 1'b0;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_write_en = 1'b1;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;

        if (reset) begin
            pc_write_en = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            ex_mem_flush = 1'b1;
            next_state  = ST_RUN;
            next_cnt    = '0;
        end else begin
            unique case (state)
                ST_RUN: begin
                    if (hz.ex_muldiv_valid) begin
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_write_en = 1'b0;
                        ex_mem_flush   = 1'b1;
                        hazard_stall   = 1'b1;
                        next_cnt       = CNT_LOAD;
                        next_state     = ST_MULDIV;
                    end else if (hz.ex_branch_taken) begin
                        pc_redirect   = 1'b1;
                        if_id_flush   = 1'b1;
                        id_ex_flush   = 1'b1;
                        branch_accept = 1'b1;
                    end else if (load_use) begin
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_flush    = 1'b1;
                        hazard_stall   = 1'b1;
                    end else if (!hz.imem_ready) begin
                        pc_write_en = 1'b0;
                        if_id_flush = 1'b1;
                    end
                end
                ST_MULDIV: begin
                    // EX is occupied; only the fetch side is still watched
                    if (cnt != '0) begin
                        pc_write_en    = 1'b0;
                        if_id_write_en = 1'b0;
                        id_ex_write_en = 1'b0;
                        ex_mem_flush   = 1'b1;
                        hazard_stall   = 1'b1;
                        next_cnt       = cnt - CNT_W'(1);
                    end else begin
                        next_state = ST_RUN;
                        if (!hz.imem_ready) begin
                            pc_write_en = 1'b0;
                            if_id_flush = 1'b1;
                        end
                    end
                end
                default: begin
                    next_state = ST_RUN;
                    next_cnt   = '0;
                end
            endcase
        end
    end

    assign hz.pc_write_en    = pc_write_en;
    assign hz.pc_redirect    = pc_redirect;
    assign hz.if_id_write_en = if_id_write_en;
    assign hz.if_id_flush    = if_id_flush;
    assign hz.id_ex_write_en = id_ex_write_en;
    assign hz.id_ex_flush    = id_ex_flush;
    assign hz.ex_mem_flush   = ex_mem_flush;

`ifdef HAZARD_STATS_EN
    // Saturating event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cycles <= 32'd0;
            flush_events <= 32'd0;
        end else begin
            if (hazard_stall && (stall_cycles != 32'hFFFF_FFFF))
                stall_cycles <= stall_cycles + 32'd1;
            if (branch_accept && (flush_events != 32'hFFFF_FFFF))
                flush_events <= flush_events + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl (MULDIV_CYCLES = 4).
module tb_pipeline_hazard_ctrl;

    logic clk;
    logic reset;

    pipeline_hazard_ctrl_if hz ();

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_events;
`endif

    pipeline_hazard_ctrl #(
        .MULDIV_CYCLES(4),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .reset(reset),
        .hz(hz)
`ifdef HAZARD_STATS_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_events(flush_events)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc_we, redirect, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_flush}
    localparam logic [6:0] O_DEF   = 7'b1010100;
    localparam logic [6:0] O_RST   = 7'b0011111;
    localparam logic [6:0] O_STALL = 7'b0000001;
    localparam logic [6:0] O_BR    = 7'b1111110;
    localparam logic [6:0] O_LU    = 7'b0000110;
    localparam logic [6:0] O_IMEM  = 7'b0011100;

    typedef struct {
        logic       rst;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       mrd;
        logic       md;
        logic       br;
        logic       imr;
        logic [6:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   tests  = 0;
    int   failed = 0;
    int   exp_stall = 0;
    int   exp_flush = 0;

    function automatic vec_t mk(input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic use1, input logic use2, input logic [4:0] rd,
                                input logic mrd, input logic md, input logic br,
                                input logic imr, input logic [6:0] exp);
        vec_t v;
        v.rst = rst; v.rs1 = rs1; v.rs2 = rs2; v.use1 = use1; v.use2 = use2;
        v.rd = rd; v.mrd = mrd; v.md = md; v.br = br; v.imr = imr; v.exp = exp;
        return v;
    endfunction

    function automatic vec_t idle(input logic [6:0] exp);
        return mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, exp);
    endfunction

    function automatic vec_t muldiv(input logic rst, input logic imr, input logic [6:0] exp);
        return mk(rst, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, imr, exp);
    endfunction

    task automatic run_vec(input vec_t v, input string name);
        logic [6:0] act;
        @(negedge clk);
        reset              = v.rst;
        hz.id_rs1          = v.rs1;
        hz.id_rs2          = v.rs2;
        hz.id_use_rs1      = v.use1;
        hz.id_use_rs2      = v.use2;
        hz.ex_rd           = v.rd;
        hz.ex_mem_read     = v.mrd;
        hz.ex_muldiv_valid = v.md;
        hz.ex_branch_taken = v.br;
        hz.imem_ready      = v.imr;
        #1;
        act = {hz.pc_write_en, hz.pc_redirect, hz.if_id_write_en, hz.if_id_flush,
               hz.id_ex_write_en, hz.id_ex_flush, hz.ex_mem_flush};
        tests++;
        if (act !== v.exp) begin
            failed++;
            $display("FAIL %s: controls %b, expected %b", name, act, v.exp);
        end
`ifdef HAZARD_STATS_EN
        tests++;
        if (stall_cycles !== 32'(exp_stall) || flush_events !== 32'(exp_flush)) begin
            failed++;
            $display("FAIL %s_stats: stall=%0d flush=%0d, expected stall=%0d flush=%0d",
                     name, stall_cycles, flush_events, exp_stall, exp_flush);
        end
`endif
        // counters observed next cycle reflect this cycle's events
        if (v.rst) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (v.exp == O_STALL || v.exp == O_LU) exp_stall++;
            if (v.exp == O_BR) exp_flush++;
        end
    endtask

    initial begin
        reset              = 1'b1;
        hz.id_rs1          = '0;
        hz.id_rs2          = '0;
        hz.id_use_rs1      = 1'b0;
        hz.id_use_rs2      = 1'b0;
        hz.ex_rd           = '0;
        hz.ex_mem_read     = 1'b0;
        hz.ex_muldiv_valid = 1'b0;
        hz.ex_branch_taken = 1'b0;
        hz.imem_ready      = 1'b1;

        // reset, then load-use variants
        tbl.push_back(mk(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, O_RST));
        tbl.push_back(muldiv(1'b1, 1'b1, O_RST));
        tbl.push_back(idle(O_DEF));
        tbl.push_back(mk(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, O_LU));
        tbl.push_back(mk(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1, O_DEF));
        tbl.push_back(mk(1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, O_DEF));
        tbl.push_back(mk(1'b0, 5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, O_DEF));
        tbl.push_back(mk(1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, O_LU));
        tbl.push_back(mk(1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b1, O_DEF));
        // branch beats load-use; imem wait; load-use beats imem wait
        tbl.push_back(mk(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, O_BR));
        tbl.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, O_BR));
        tbl.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_IMEM));
        tbl.push_back(mk(1'b0, 5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, O_LU));
        // MUL/DIV: 3 stall cycles, imem wait held off during stall, then exposed
        tbl.push_back(muldiv(1'b0, 1'b1, O_STALL));
        tbl.push_back(muldiv(1'b0, 1'b0, O_STALL));
        tbl.push_back(muldiv(1'b0, 1'b0, O_STALL));
        tbl.push_back(muldiv(1'b0, 1'b0, O_IMEM));
        tbl.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, O_IMEM));
        // MUL/DIV with an illegal branch, then LU/branch ignored in the exit cycle
        tbl.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, O_STALL));
        tbl.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, O_STALL));
        tbl.push_back(mk(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, O_STALL));
        tbl.push_back(mk(1'b0, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, O_DEF));
        tbl.push_back(idle(O_DEF));

        foreach (tbl[i]) run_vec(tbl[i], $sformatf("vec%0d", i));

        // back-to-back MUL/DIV: second one re-detected right after the exit cycle
        for (int k = 0; k < 2; k++) begin
            run_vec(muldiv(1'b0, 1'b1, O_STALL), $sformatf("b2b%0d_s1", k));
            run_vec(muldiv(1'b0, 1'b1, O_STALL), $sformatf("b2b%0d_s2", k));
            run_vec(muldiv(1'b0, 1'b1, O_STALL), $sformatf("b2b%0d_s3", k));
            run_vec(muldiv(1'b0, 1'b1, O_DEF),   $sformatf("b2b%0d_exit", k));
        end
        run_vec(idle(O_DEF), "b2b_after");

        // reset in the 2nd stall cycle aborts; a fresh MUL/DIV then gets a full stall
        run_vec(muldiv(1'b0, 1'b1, O_STALL), "rst_md_s1");
        run_vec(muldiv(1'b1, 1'b1, O_RST),   "rst_md_in_reset");
        run_vec(idle(O_DEF),                 "rst_md_post");
        run_vec(muldiv(1'b0, 1'b1, O_STALL), "rst_md_new_s1");
        run_vec(muldiv(1'b0, 1'b1, O_STALL), "rst_md_new_s2");
        run_vec(muldiv(1'b0, 1'b1, O_STALL), "rst_md_new_s3");
        run_vec(muldiv(1'b0, 1'b1, O_DEF),   "rst_md_new_exit");
        run_vec(idle(O_DEF),                 "final_idle");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
